// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter with prioritised redirects and stall-deferred redirect latch
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter int                STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_0180,
  parameter int                OFF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_step,
  input  logic [ADDR_W-1:0] redir_base,
  input  logic              br_taken,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic              j_en,
  input  logic [25:0]       j_index,
  input  logic              jr_en,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              exc_en,
  output logic              redirect_pending
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_PEND} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pend_target, pend_target_nxt;
  logic [1:0]        pend_prio, pend_prio_nxt;
  logic              redir;
  logic [1:0]        redir_prio;
  logic [ADDR_W-1:0] redir_target;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic              redir_wins;

  assign pc_plus_step = pc + ADDR_W'(STEP);
  assign br_target    = redir_base + {{(ADDR_W-OFF_W-2){br_offset[OFF_W-1]}}, br_offset, 2'b00};
  assign j_target     = {redir_base[ADDR_W-1:28], j_index, 2'b00};

  // Priority rank: exc=3, jr=2, j=1, br=0; compared against the held rank while pending.
  always_comb begin
    redir        = 1'b1;
    redir_prio   = 2'd0;
    redir_target = br_target;
    if (exc_en) begin
      redir_prio   = 2'd3;
      redir_target = EXC_VEC;
    end else if (jr_en) begin
      redir_prio   = 2'd2;
      redir_target = jr_target;
    end else if (j_en) begin
      redir_prio   = 2'd1;
      redir_target = j_target;
    end else if (!br_taken) begin
      redir = 1'b0;
    end
  end

  assign redir_wins = redir && (redir_prio >= pend_prio);

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pend_target_nxt = pend_target;
    pend_prio_nxt   = pend_prio;
    case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN: begin
        if (redir && !stall) begin
          pc_nxt = redir_target;
        end else if (redir) begin
          pend_target_nxt = redir_target;
          pend_prio_nxt   = redir_prio;
          state_nxt       = S_PEND;
        end else if (!stall && if_ready) begin
          pc_nxt = pc_plus_step;
        end
      end
      S_PEND: begin
        if (stall) begin
          if (redir_wins) begin
            pend_target_nxt = redir_target;
            pend_prio_nxt   = redir_prio;
          end
        end else begin
          pc_nxt    = redir_wins ? redir_target : pend_target;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_VEC;
      pend_target <= '0;
      pend_prio   <= 2'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_target <= pend_target_nxt;
      pend_prio   <= pend_prio_nxt;
    end
  end

  assign if_valid         = (state != S_BOOT);
  assign redirect_pending = (state == S_PEND);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, if_ready, br_taken, j_en, jr_en, exc_en;
  logic        if_valid, redirect_pending;
  logic [31:0] pc, pc_plus_step, redir_base, jr_target;
  logic [15:0] br_offset;
  logic [25:0] j_index;

  int errors = 0;
  int checks = 0;

  // Reference model state: boot flag, pc, and a deferred redirect with its rank.
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pt;
  int          m_pp;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_ready(if_ready),
    .if_valid(if_valid), .pc(pc), .pc_plus_step(pc_plus_step),
    .redir_base(redir_base), .br_taken(br_taken), .br_offset(br_offset),
    .j_en(j_en), .j_index(j_index), .jr_en(jr_en), .jr_target(jr_target),
    .exc_en(exc_en), .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Candidate redirects as (rank, target); the highest rank present wins.
  task automatic pick(output bit have, output int prio, output logic [31:0] tgt);
    int          rank [4];
    logic [31:0] addr [4];
    bit          on   [4];
    int          sx;
    sx = int'($signed(br_offset));
    on[0] = br_taken; rank[0] = 0; addr[0] = redir_base + 32'(sx * 4);
    on[1] = j_en;     rank[1] = 1; addr[1] = (redir_base & 32'hF000_0000) | (32'(j_index) * 4);
    on[2] = jr_en;    rank[2] = 2; addr[2] = jr_target;
    on[3] = exc_en;   rank[3] = 3; addr[3] = 32'h180;
    have = 0; prio = -1; tgt = '0;
    for (int i = 0; i < 4; i++)
      if (on[i] && rank[i] > prio) begin
        have = 1; prio = rank[i]; tgt = addr[i];
      end
  endtask

  task automatic model_step();
    bit          have;
    int          prio;
    logic [31:0] tgt;
    pick(have, prio, tgt);
    if (m_boot) m_boot = 0;
    else if (m_pend) begin
      if (stall) begin
        if (have && prio >= m_pp) begin m_pt = tgt; m_pp = prio; end
      end else begin
        m_pc   = (have && prio >= m_pp) ? tgt : m_pt;
        m_pend = 0;
      end
    end else if (have) begin
      if (!stall) m_pc = tgt;
      else begin m_pend = 1; m_pt = tgt; m_pp = prio; end
    end else if (!stall && if_ready) m_pc = m_pc + 32'd4;
  endtask

  task automatic model_reset();
    m_boot = 1; m_pc = 32'h0; m_pend = 0; m_pt = '0; m_pp = 0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pps"}, pc_plus_step, m_pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, !m_boot});
    chk({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, m_pend});
  endtask

  task automatic clr();
    br_taken = 0; j_en = 0; jr_en = 0; exc_en = 0;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    cmp_model(tag);
  endtask

  initial begin
    rst_n = 0; stall = 0; if_ready = 1; clr();
    redir_base = '0; br_offset = '0; j_index = '0; jr_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc", pc, 32'h0);
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.pend", {31'd0, redirect_pending}, 32'd0);
    rst_n = 1;
    #1 chk("boot.valid", {31'd0, if_valid}, 32'd0);
    cyc("boot");
    chk("seq0", pc, 32'h0);
    cyc("seq1"); chk("seq1.exp", pc, 32'h4);
    cyc("seq2"); chk("seq2.exp", pc, 32'h8);

    jr_en = 1; jr_target = 32'h100;
    cyc("jr"); clr(); chk("jr.exp", pc, 32'h100);
    if_ready = 0;
    repeat (3) cyc("hold");
    chk("hold.exp", pc, 32'h100);
    if_ready = 1;
    cyc("adv"); chk("adv.exp", pc, 32'h104);

    redir_base = 32'h200; br_taken = 1; br_offset = 16'hFFFE;
    cyc("br"); chk("br.exp", pc, 32'h1F8);
    exc_en = 1;
    cyc("brexc"); clr(); chk("brexc.exp", pc, 32'h180);

    stall = 1; j_en = 1; redir_base = 32'h4000_0010; j_index = 26'h40;
    cyc("jst"); clr();
    chk("jst.pend", {31'd0, redirect_pending}, 32'd1);
    chk("jst.pc", pc, 32'h180);
    stall = 0;
    cyc("jrel"); chk("jrel.exp", pc, 32'h4000_0100);
    chk("jrel.pend", {31'd0, redirect_pending}, 32'd0);

    stall = 1; redir_base = 32'h300; br_offset = 16'h0; br_taken = 1;
    cyc("pb"); clr(); exc_en = 1;
    cyc("pbexc"); clr(); stall = 0;
    cyc("pbrel"); chk("pbrel.exp", pc, 32'h180);
    stall = 1; exc_en = 1;
    cyc("pe"); clr(); br_taken = 1;
    cyc("pebr"); clr(); stall = 0;
    cyc("perel"); chk("perel.exp", pc, 32'h180);

    stall = 1; br_taken = 1;
    cyc("pr"); clr();
    chk("pr.pend", {31'd0, redirect_pending}, 32'd1);
    rst_n = 0;
    #1;
    model_reset();
    cmp_model("async");
    chk("async.pc", pc, 32'h0);
    stall = 0;
    cyc("inrst");
    rst_n = 1;
    cyc("boot2");
    chk("boot2.valid", {31'd0, if_valid}, 32'd1);

    jr_en = 1; jr_target = 32'hFFFF_FFFC;
    cyc("top"); clr(); chk("top.exp", pc, 32'hFFFF_FFFC);
    chk("top.pps", pc_plus_step, 32'h0);
    cyc("wrap"); chk("wrap.exp", pc, 32'h0);

    for (int i = 0; i < 400; i++) begin
      stall      = ($urandom % 4) == 0;
      if_ready   = ($urandom % 4) != 0;
      br_taken   = ($urandom % 6) == 0;
      j_en       = ($urandom % 8) == 0;
      jr_en      = ($urandom % 8) == 0;
      exc_en     = ($urandom % 12) == 0;
      redir_base = $urandom;
      br_offset  = 16'($urandom);
      j_index    = 26'($urandom);
      jr_target  = $urandom;
      cyc("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit; successor to the fixed PC+4 adder.
- Holds the fetch PC in a register and produces the sequential next PC (PC+STEP).
- Selects among exception, jump-register, jump, taken-branch and sequential next-PC sources.
- Latches a redirect that arrives during a stall and applies it once the stall clears; drives a valid/ready fetch request toward instruction memory.

Parameters:
- ADDR_W, 32, PC width in bits; must be at least 32.
- STEP, 4, sequential increment in bytes.
- RESET_VEC, 32'h0000_0000, first fetch address after reset.
- EXC_VEC, 32'h0000_0180, exception entry address.
- OFF_W, 16, branch offset width in words, sign-extended.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline hold; freezes the PC and defers redirects.
- if_ready  in  1  instruction memory accepts the current request.
- if_valid  out  1  fetch request at pc is valid.
- pc  out  ADDR_W  current fetch address.
- pc_plus_step  out  ADDR_W  pc+STEP, combinational from pc.
- redir_base  in  ADDR_W  PC+STEP of the redirecting instruction.
- br_taken  in  1  taken-branch redirect.
- br_offset  in  OFF_W  signed word offset.
- j_en  in  1  direct jump redirect.
- j_index  in  26  jump word index.
- jr_en  in  1  register jump redirect.
- jr_target  in  ADDR_W  register jump address.
- exc_en  in  1  exception redirect.
- redirect_pending  out  1  a deferred redirect is held.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_VEC, if_valid=0, redirect_pending=0, state=S_BOOT.
  - pending target register cleared to 0.
- Arithmetic (all results wrap modulo 2^ADDR_W, no overflow flag):
  - pc_plus_step = pc+STEP.
  - Branch target = redir_base + (sext(br_offset)<<2).
  - Jump target = {redir_base[ADDR_W-1:28], j_index, 2'b00}.
  - Jump-register target = jr_target unmodified; no alignment check.
- Redirect priority, same cycle, highest first: exc_en > jr_en > j_en > br_taken. Exactly one target is selected; lower sources are dropped.
- State S_BOOT:
  - Lasts one cycle after rst_n deasserts; if_valid=0, pc holds RESET_VEC.
  - Next state is S_RUN unconditionally.
  - Redirect inputs are ignored in S_BOOT.
- State S_RUN:
  - if_valid=1.
  - Redirect and stall=0: pc<=selected target at the next edge, even when if_ready=0 (the in-flight wrong-path fetch is abandoned).
  - Redirect and stall=1: target is latched into the pending register, redirect_pending<=1, pc unchanged, go to S_PEND.
  - No redirect, stall=0, if_ready=1: pc<=pc_plus_step.
  - No redirect and either stall=1 or if_ready=0: pc holds.
- State S_PEND:
  - if_valid=1; redirect_pending=1; pc holds.
  - New redirect while stall=1: overwrites the pending target only if its priority is greater than or equal to the priority of the held source. The held source's priority is stored alongside the target.
  - stall=0: pc <= a same-cycle redirect if its priority is at least the held priority, else pc <= the pending target. redirect_pending<=0; go to S_RUN.
- Latency: redirect-to-pc is 1 cycle when unstalled; when stalled, pc updates on the first edge with stall=0.
- Reset mid-operation: pending redirect discarded, return to S_BOOT.
- Outputs pc, if_valid and redirect_pending are registered or state-decoded; only pc_plus_step is combinational.

Test Plan:
- Release reset with stall=0, if_ready=1 -> if_valid=0 for 1 cycle, then pc=0x0, 0x4, 0x8 on successive cycles.
- S_RUN at pc=0x100, if_ready=0 for 3 cycles -> pc holds 0x100, then advances to 0x104 when if_ready=1.
- redir_base=0x200, br_taken=1, br_offset=16'hFFFE -> pc=0x1F8 next cycle. Repeat with exc_en=1 in the same cycle -> pc=0x180.
- stall=1, j_en=1, redir_base=0x4000_0010, j_index=0x40 -> redirect_pending=1, pc unchanged. On stall=0 -> pc=0x4000_0100, redirect_pending=0.
- Stalled with pending branch target 0x300; exc_en=1 arrives still stalled -> on stall release pc=0x180. Reverse order (exc pending, then branch) -> pc=0x180.
- rst_n pulsed low while in S_PEND -> pc=RESET_VEC, redirect_pending=0 immediately, without waiting for a clock edge; S_BOOT cycle follows. Also pc=0xFFFF_FFFC, stall=0, if_ready=1 -> pc wraps to 0x0.
